// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, reset PC,
// and the held-instruction record handed to decode.
package fetch_stage_pkg;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [63:0] INSTR_BYTES      = 64'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding for pc
        DROP  = 2'd1,   // request for a stale pc still in flight; result discarded
        HOLD  = 2'd2    // instruction held for decode
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } fetch_data_t;

    // Sequential next PC; 64-bit wraparound is intentional.
    function automatic logic [63:0] seq_next_pc(input logic [63:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: instruction bus, redirect from execute,
// stall from decode/hazard, and the held instruction toward decode.
interface fetch_stage_if;

    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_raw_instr;

    // Fetch stage side
    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  stall,
        output out_valid,
        output out_pc,
        output out_raw_instr
    );

    // Bus, execute and decode side
    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data,
        output redirect_valid,
        output redirect_pc,
        output stall,
        input  out_valid,
        input  out_pc,
        input  out_raw_instr
    );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one bus request at a time,
// holds one fetched instruction for decode, and handles execute redirects
// including those that land while a request is still outstanding.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic          clk,
    input  logic          resetn,
    fetch_stage_if.master bus
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  pend_pc_q, pend_pc_d;
    fetch_data_t  out_q, out_d;

    // State, PC, pending redirect target and held instruction registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= FETCH;
            pc_q      <= PC_RESET;
            pend_pc_q <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            out_q     <= out_d;
        end
    end

    // Next-state and next-PC selection; redirect outranks stall in every state
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        out_d     = out_q;

        unique case (state_q)
            FETCH: begin
                if (bus.iresp_data_ok) begin
                    if (bus.redirect_valid) begin
                        pc_d = bus.redirect_pc;
                    end else begin
                        state_d         = HOLD;
                        out_d.valid     = 1'b1;
                        out_d.pc        = pc_q;
                        out_d.raw_instr = bus.iresp_data;
                    end
                end else if (bus.redirect_valid) begin
                    // The bus cannot cancel: wait out the stale request, keep the target
                    state_d   = DROP;
                    pend_pc_d = bus.redirect_pc;
                end
            end

            DROP: begin
                if (bus.redirect_valid) begin
                    pend_pc_d = bus.redirect_pc;
                end
                if (bus.iresp_data_ok) begin
                    state_d = FETCH;
                    pc_d    = bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
                end
            end

            HOLD: begin
                if (bus.redirect_valid) begin
                    state_d     = FETCH;
                    out_d.valid = 1'b0;
                    pc_d        = bus.redirect_pc;
                end else if (!bus.stall) begin
                    state_d     = FETCH;
                    out_d.valid = 1'b0;
                    pc_d        = seq_next_pc(pc_q);
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Bus request is a pure function of state and pc; suppressed during reset
    always_comb begin
        bus.ireq_valid = resetn && ((state_q == FETCH) || (state_q == DROP));
        bus.ireq_addr  = pc_q;
    end

    // Held instruction toward decode
    always_comb begin
        bus.out_valid     = out_q.valid;
        bus.out_pc        = out_q.pc;
        bus.out_raw_instr = out_q.raw_instr;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. Inputs change on the falling
// edge; outputs are checked on the falling edge (or shortly after an input change).
module tb_fetch_stage;

    logic clk;
    logic resetn;
    int   tests_run;
    int   tests_failed;

    fetch_stage_if bus ();

    fetch_stage #(
        .PC_RESET(64'h0000_0000_8000_0000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the bench's bus returns for a given address
    function automatic logic [31:0] instr_for(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        tests_run++; if (bus.ireq_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ireq_valid: got %0b expected 0", bus.ireq_valid); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        tests_run++; if (bus.out_pc !== 64'h0) begin tests_failed++; $display("FAIL reset_out_pc: got %h expected 0", bus.out_pc); end
        tests_run++; if (bus.out_raw_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_out_raw: got %h expected 0", bus.out_raw_instr); end
        resetn = 1'b1;
        #1;
        tests_run++; if (bus.ireq_valid !== 1'b1) begin tests_failed++; $display("FAIL reset_release_req: got %0b expected 1", bus.ireq_valid); end
        tests_run++; if (bus.ireq_addr !== 64'h8000_0000) begin tests_failed++; $display("FAIL reset_release_addr: got %h expected 80000000", bus.ireq_addr); end
    endtask

    task automatic test_zero_wait();
        logic [63:0] a;
        for (int k = 0; k < 3; k++) begin
            a = 64'h8000_0000 + 64'(4 * k);
            tests_run++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== a) begin tests_failed++; $display("FAIL zw_req[%0d]: got v=%0b a=%h expected v=1 a=%h", k, bus.ireq_valid, bus.ireq_addr, a); end
            tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL zw_out_low[%0d]: got %0b expected 0", k, bus.out_valid); end
            bus.iresp_data_ok = 1'b1;
            bus.iresp_data    = instr_for(a);
            tick();
            bus.iresp_data_ok = 1'b0;
            bus.iresp_data    = '0;
            tests_run++; if (bus.ireq_valid !== 1'b0) begin tests_failed++; $display("FAIL zw_req_idle[%0d]: got %0b expected 0", k, bus.ireq_valid); end
            tests_run++; if (bus.out_valid !== 1'b1 || bus.out_pc !== a || bus.out_raw_instr !== instr_for(a)) begin tests_failed++; $display("FAIL zw_out[%0d]: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h", k, bus.out_valid, bus.out_pc, bus.out_raw_instr, a, instr_for(a)); end
            tick();
        end
    endtask

    task automatic test_wait();
        logic [63:0] a;
        a = 64'h8000_000C;
        for (int w = 0; w < 4; w++) begin
            tests_run++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== a) begin tests_failed++; $display("FAIL wait_req[%0d]: got v=%0b a=%h expected v=1 a=%h", w, bus.ireq_valid, bus.ireq_addr, a); end
            tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL wait_out_low[%0d]: got %0b expected 0", w, bus.out_valid); end
            bus.iresp_data_ok = (w == 3);
            bus.iresp_data    = (w == 3) ? instr_for(a) : 32'hDEAD_BEEF;
            tick();
        end
        bus.iresp_data_ok = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_pc !== a || bus.out_raw_instr !== instr_for(a)) begin tests_failed++; $display("FAIL wait_out: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h", bus.out_valid, bus.out_pc, bus.out_raw_instr, a, instr_for(a)); end
    endtask

    task automatic test_stall();
        logic [63:0] a;
        a = 64'h8000_000C;
        bus.stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            tests_run++; if (bus.out_valid !== 1'b1 || bus.out_pc !== a || bus.out_raw_instr !== instr_for(a)) begin tests_failed++; $display("FAIL stall_hold[%0d]: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h", s, bus.out_valid, bus.out_pc, bus.out_raw_instr, a, instr_for(a)); end
            tests_run++; if (bus.ireq_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_no_req[%0d]: got %0b expected 0", s, bus.ireq_valid); end
        end
        bus.stall = 1'b0;
        tick();
        tests_run++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0010) begin tests_failed++; $display("FAIL stall_next_req: got v=%0b a=%h expected v=1 a=80000010", bus.ireq_valid, bus.ireq_addr); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_released_out: got %0b expected 0", bus.out_valid); end
    endtask

    task automatic test_redirect_inflight();
        for (int c = 0; c < 4; c++) begin
            tests_run++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0010) begin tests_failed++; $display("FAIL rdi_req[%0d]: got v=%0b a=%h expected v=1 a=80000010", c, bus.ireq_valid, bus.ireq_addr); end
            bus.redirect_valid = (c == 2);
            bus.redirect_pc    = 64'h8000_0100;
            bus.iresp_data_ok  = (c == 3);
            bus.iresp_data     = instr_for(64'h8000_0010);
            tick();
        end
        bus.redirect_valid = 1'b0;
        bus.iresp_data_ok  = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rdi_discard: got out_valid=%0b expected 0", bus.out_valid); end
        tests_run++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0100) begin tests_failed++; $display("FAIL rdi_target: got v=%0b a=%h expected v=1 a=80000100", bus.ireq_valid, bus.ireq_addr); end
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data    = instr_for(64'h8000_0100);
        tick();
        bus.iresp_data_ok = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_0100 || bus.out_raw_instr !== instr_for(64'h8000_0100)) begin tests_failed++; $display("FAIL rdi_target_out: got v=%0b pc=%h i=%h expected v=1 pc=80000100 i=%h", bus.out_valid, bus.out_pc, bus.out_raw_instr, instr_for(64'h8000_0100)); end
        tick();
    endtask

    task automatic test_back_to_back();
        // Two redirects during DROP: the later one wins
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0200;
        tick();
        bus.redirect_pc = 64'h8000_0300;
        tick();
        bus.redirect_valid = 1'b0;
        tests_run++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0104) begin tests_failed++; $display("FAIL b2b_drop_addr: got v=%0b a=%h expected v=1 a=80000104", bus.ireq_valid, bus.ireq_addr); end
        bus.iresp_data_ok = 1'b1; bus.iresp_data = 32'hAAAA_5555;
        tick();
        bus.iresp_data_ok = 1'b0;
        tests_run++; if (bus.ireq_addr !== 64'h8000_0300 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_latest: got a=%h ov=%0b expected a=80000300 ov=0", bus.ireq_addr, bus.out_valid); end

        // Redirect in DROP together with data_ok: that redirect target is taken
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0400;
        tick();
        bus.redirect_pc = 64'h8000_0500; bus.iresp_data_ok = 1'b1;
        tick();
        bus.redirect_valid = 1'b0; bus.iresp_data_ok = 1'b0;
        tests_run++; if (bus.ireq_addr !== 64'h8000_0500 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drop_same_cycle: got a=%h ov=%0b expected a=80000500 ov=0", bus.ireq_addr, bus.out_valid); end

        // Redirect coinciding with data_ok in FETCH
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0600; bus.iresp_data_ok = 1'b1;
        tick();
        bus.redirect_valid = 1'b0; bus.iresp_data_ok = 1'b0;
        tests_run++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0600 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_fetch_redirect: got v=%0b a=%h ov=%0b expected v=1 a=80000600 ov=0", bus.ireq_valid, bus.ireq_addr, bus.out_valid); end

        // Redirect in HOLD beats stall and drops the held instruction
        bus.iresp_data_ok = 1'b1; bus.iresp_data = instr_for(64'h8000_0600);
        tick();
        bus.iresp_data_ok = 1'b0;
        bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0700;
        tick();
        bus.stall = 1'b0; bus.redirect_valid = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b0 || bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0700) begin tests_failed++; $display("FAIL b2b_hold_redirect: got ov=%0b v=%0b a=%h expected ov=0 v=1 a=80000700", bus.out_valid, bus.ireq_valid, bus.ireq_addr); end
    endtask

    task automatic test_wrap();
        // Unaligned target passes through; pc+4 wraps at 64 bits
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE; bus.iresp_data_ok = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        tests_run++; if (bus.ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL wrap_unaligned: got %h expected fffffffffffffffe", bus.ireq_addr); end
        bus.iresp_data = 32'h0000_0013;
        tick();
        bus.iresp_data_ok = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFE || bus.out_raw_instr !== 32'h0000_0013) begin tests_failed++; $display("FAIL wrap_out: got v=%0b pc=%h i=%h expected v=1 pc=fffffffffffffffe i=00000013", bus.out_valid, bus.out_pc, bus.out_raw_instr); end
        tick();
        tests_run++; if (bus.ireq_addr !== 64'h0000_0000_0000_0002) begin tests_failed++; $display("FAIL wrap_next: got %h expected 0000000000000002", bus.ireq_addr); end
    endtask

    task automatic test_reset_mid();
        tick();
        tests_run++; if (bus.ireq_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_inflight: got %0b expected 1", bus.ireq_valid); end
        resetn = 1'b0;
        #1;
        tests_run++; if (bus.ireq_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_req_low: got %0b expected 0", bus.ireq_valid); end
        tick();
        tests_run++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 64'h0) begin tests_failed++; $display("FAIL rstmid_out: got v=%0b pc=%h expected v=0 pc=0", bus.out_valid, bus.out_pc); end
        resetn = 1'b1;
        #1;
        tests_run++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0000) begin tests_failed++; $display("FAIL rstmid_restart: got v=%0b a=%h expected v=1 a=80000000", bus.ireq_valid, bus.ireq_addr); end
        bus.iresp_data_ok = 1'b1; bus.iresp_data = instr_for(64'h8000_0000);
        tick();
        bus.iresp_data_ok = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_0000 || bus.out_raw_instr !== instr_for(64'h8000_0000)) begin tests_failed++; $display("FAIL rstmid_first_out: got v=%0b pc=%h i=%h expected v=1 pc=80000000 i=%h", bus.out_valid, bus.out_pc, bus.out_raw_instr, instr_for(64'h8000_0000)); end
    endtask

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        resetn             = 1'b0;
        bus.iresp_data_ok  = 1'b0;
        bus.iresp_data     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.stall          = 1'b0;

        test_reset();
        test_zero_wait();
        test_wait();
        test_stall();
        test_redirect_inflight();
        test_back_to_back();
        test_wrap();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
